// File: rtl/pdp8_pkg.sv
// Shared CPLDP-8 definitions: BIN loader state encoding, special tape bytes
// and the byte-class decoder used by the paper-tape loader.
package pdp8_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      HI,
      LO,
      CHECK,
      FIN
   } load_state_t;

   typedef enum logic [2:0] {
      CLS_LEADER,
      CLS_RUBOUT,
      CLS_FIELD,
      CLS_ORIGIN,
      CLS_DATA,
      CLS_OTHER
   } byte_class_t;

   localparam logic [7:0] BIN_LEADER = 8'h80;
   localparam logic [7:0] BIN_RUBOUT = 8'hFF;

   // Leader and rubout are exact codes, so they are tested before the
   // bit-pattern classes they would otherwise alias.
   function automatic byte_class_t classify_byte(input logic [7:0] b);
      if (b == BIN_LEADER)
         return CLS_LEADER;
      else if (b == BIN_RUBOUT)
         return CLS_RUBOUT;
      else if (b[7:6] == 2'b11 && b[2:0] == 3'b000)
         return CLS_FIELD;
      else if (b[7:6] == 2'b01)
         return CLS_ORIGIN;
      else if (b[7:6] == 2'b00)
         return CLS_DATA;
      else
         return CLS_OTHER;
   endfunction

endpackage

// File: rtl/bin_loader.sv
// Paper-tape BIN loader: decodes leader, origin, field and data frames from
// the serial receiver and writes words to RAM, checking the trailing checksum.
module bin_loader
   import pdp8_pkg::*;
#(
   parameter int MIN_LEADER = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [11:0] mem_addr,
   output logic [2:0]  mem_field,
   output logic [11:0] mem_wdata,
   output logic        mem_we,
   output logic        busy,
   output logic        done,
   output logic        cksum_err
);

   localparam int CW = $clog2(MIN_LEADER + 1) + 1;

   load_state_t   state;
   byte_class_t   cls;
   logic [7:0]    hi_latch;
   logic [7:0]    pend_hi;
   logic [7:0]    pend_lo;
   logic          pend_valid;
   logic          pend_is_data;
   logic [11:0]   pend_word;
   logic [11:0]   addr_cnt;
   logic [11:0]   cksum;
   logic [2:0]    field;
   logic [CW-1:0] lead_cnt;
   logic          lead_ok;
   logic          hi_phase;
   logic          lo_phase;
   logic          do_commit;

   // hi_phase also covers the first frame byte after a long-enough leader,
   // which is handled exactly as if the loader were already in HI.
   always_comb begin
      cls       = classify_byte(rx_data);
      pend_word = {pend_hi[5:0], pend_lo[5:0]};
      lead_ok   = (lead_cnt >= CW'(MIN_LEADER));
      hi_phase  = rx_valid && ((state == HI) ||
                  (state == LEAD && lead_ok && cls != CLS_LEADER && cls != CLS_RUBOUT));
      lo_phase  = rx_valid && (state == LO) && (cls != CLS_RUBOUT) && (rx_data[7:6] == 2'b00);
      do_commit = pend_valid && ((hi_phase && cls == CLS_FIELD) || lo_phase);
   end

   // Single sequential block: state machine, frame datapath and the commit of
   // the previously pending frame, which always reads the pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         hi_latch     <= '0;
         pend_hi      <= '0;
         pend_lo      <= '0;
         pend_valid   <= 1'b0;
         pend_is_data <= 1'b0;
         addr_cnt     <= '0;
         cksum        <= '0;
         field        <= '0;
         lead_cnt     <= '0;
         mem_addr     <= '0;
         mem_field    <= '0;
         mem_wdata    <= '0;
         mem_we       <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         cksum_err    <= 1'b0;
      end else begin
         mem_we <= 1'b0;

         case (state)
            IDLE, CHECK, FIN: begin
               if (state == CHECK)
                  state <= FIN;
               if (start) begin
                  state      <= LEAD;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  cksum_err  <= 1'b0;
                  lead_cnt   <= '0;
                  cksum      <= '0;
                  pend_valid <= 1'b0;
                  field      <= '0;
               end
            end
            LEAD: begin
               if (rx_valid && !hi_phase) begin
                  if (cls == CLS_LEADER) begin
                     if (!lead_ok)
                        lead_cnt <= lead_cnt + CW'(1);
                  end else if (cls != CLS_RUBOUT) begin
                     lead_cnt <= '0;
                  end
               end
            end
            LO: begin
               if (rx_valid && cls != CLS_RUBOUT) begin
                  if (rx_data[7:6] != 2'b00) begin
                     cksum_err <= 1'b1;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     state     <= FIN;
                  end else begin
                     pend_hi      <= hi_latch;
                     pend_lo      <= rx_data;
                     pend_is_data <= (hi_latch[6] == 1'b0);
                     pend_valid   <= 1'b1;
                     state        <= HI;
                  end
               end
            end
            default: ;
         endcase

         if (hi_phase) begin
            case (cls)
               CLS_ORIGIN, CLS_DATA: begin
                  hi_latch <= rx_data;
                  state    <= LO;
               end
               CLS_FIELD: begin
                  field <= rx_data[5:3];
                  state <= HI;
               end
               CLS_LEADER: begin
                  if (pend_valid) begin
                     cksum_err <= (cksum != pend_word);
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     state     <= CHECK;
                  end
               end
               default: state <= HI;
            endcase
         end

         // The address counter wraps inside the 12-bit space and never
         // carries into the field register.
         if (do_commit) begin
            cksum <= cksum + 12'(pend_hi) + 12'(pend_lo);
            if (pend_is_data) begin
               mem_we    <= 1'b1;
               mem_field <= field;
               mem_addr  <= addr_cnt;
               mem_wdata <= pend_word;
               addr_cnt  <= addr_cnt + 12'd1;
            end else begin
               addr_cnt <= pend_word;
            end
         end
      end
   end

endmodule

// File: tb/tb_bin_loader.sv
// Self-checking bench for bin_loader: directed tapes plus random tapes scored
// against a tape-level reference model of the BIN format.
module tb_bin_loader;

   localparam int MIN_LEADER = 4;

   typedef struct packed {
      logic [2:0]  f;
      logic [11:0] a;
      logic [11:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [11:0] mem_addr;
   logic [2:0]  mem_field;
   logic [11:0] mem_wdata;
   logic        mem_we;
   logic        busy;
   logic        done;
   logic        cksum_err;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;

   logic [7:0]  tape[$];
   int          strobe_cyc[$];
   wr_t         obs_w[$];
   int          obs_cyc[$];
   wr_t         exp_w[$];
   logic        exp_done;
   logic        exp_err;
   logic        last_done;

   logic [2:0]  m_field;
   logic [11:0] m_addr;
   logic [11:0] m_sum;
   logic        m_have;
   logic [7:0]  m_hi;
   logic [7:0]  m_lo;

   bin_loader #(.MIN_LEADER(MIN_LEADER)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .mem_addr  (mem_addr),
      .mem_field (mem_field),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .busy      (busy),
      .done      (done),
      .cksum_err (cksum_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         obs_w.push_back({mem_field, mem_addr, mem_wdata});
         obs_cyc.push_back(cyc);
      end
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Commit the pending frame of the model: checksum, then origin or write.
   task automatic model_commit();
      if (!m_have) return;
      m_sum = m_sum + 12'(m_hi) + 12'(m_lo);
      if (m_hi[7:6] == 2'b01)
         m_addr = {m_hi[5:0], m_lo[5:0]};
      else begin
         exp_w.push_back({m_field, m_addr, {m_hi[5:0], m_lo[5:0]}});
         m_addr = m_addr + 12'd1;
      end
   endtask

   // Tape-level model: strip rubouts, find the end of a valid leader, then
   // walk the remaining bytes as field bytes, frame pairs and the trailer.
   task automatic model_tape();
      int          lead = 0;
      bit          in_frames = 0;
      logic [7:0]  f[$];
      int          i = 0;
      logic [7:0]  b;
      logic [7:0]  lo;
      exp_w.delete();
      exp_done = 1'b0;
      exp_err = 1'b0;
      m_field = '0;
      m_sum = '0;
      m_have = 1'b0;
      foreach (tape[k]) begin
         b = tape[k];
         if (b == 8'hFF) continue;
         if (!in_frames) begin
            if (b == 8'h80) begin
               lead++;
               continue;
            end
            if (lead < MIN_LEADER) begin
               lead = 0;
               continue;
            end
            in_frames = 1;
         end
         f.push_back(b);
      end
      while (i < f.size()) begin
         b = f[i];
         if (b == 8'h80) begin
            if (m_have) begin
               exp_done = 1'b1;
               exp_err = (m_sum != {m_hi[5:0], m_lo[5:0]});
               break;
            end
            i++;
         end else if (b[7:6] == 2'b11 && b[2:0] == 3'b000) begin
            model_commit();
            m_field = b[5:3];
            i++;
         end else if (b[7] == 1'b0) begin
            if (i + 1 >= f.size()) break;
            lo = f[i+1];
            if (lo[7:6] != 2'b00) begin
               exp_done = 1'b1;
               exp_err = 1'b1;
               break;
            end
            model_commit();
            m_hi = b;
            m_lo = lo;
            m_have = 1'b1;
            i += 2;
         end else begin
            i++;
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      strobe_cyc.push_back(cyc);
      last_done = done;
      repeat (2) @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_output("reset_outputs", {mem_addr, mem_field, mem_wdata, mem_we, busy, done, cksum_err}, '0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_addr = '0;
   endtask

   task automatic arm();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_output("busy_after_start", {30'd0, busy, done}, 32'h2);
   endtask

   // Arm, play the current tape, then score it against the model.
   task automatic apply_stimulus(input string tag);
      arm();
      model_tape();
      obs_w.delete();
      obs_cyc.delete();
      strobe_cyc.delete();
      foreach (tape[k]) send_byte(tape[k]);
      repeat (3) @(negedge clk);
      check_output({tag, "_nwrites"}, obs_w.size(), exp_w.size());
      for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++)
         check_output({tag, "_write"}, obs_w[i], exp_w[i]);
      check_output({tag, "_done_timing"}, last_done, exp_done);
      check_output({tag, "_done"}, done, exp_done);
      check_output({tag, "_busy"}, busy, !exp_done);
      if (exp_done)
         check_output({tag, "_cksum_err"}, cksum_err, exp_err);
   endtask

   task automatic gen_random_tape();
      logic [11:0] gsum = '0;
      logic [7:0]  hi;
      logic [7:0]  lo;
      int          n;
      tape.delete();
      repeat (MIN_LEADER + $urandom_range(0, 2)) tape.push_back(8'h80);
      if ($urandom_range(0, 1) == 1) tape.push_back({2'b11, 3'($urandom), 3'b000});
      hi = {2'b01, 6'($urandom)};
      lo = {2'b00, 6'($urandom)};
      tape.push_back(hi);
      tape.push_back(lo);
      gsum = gsum + 12'(hi) + 12'(lo);
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
         if ($urandom_range(0, 3) == 0) tape.push_back({2'b11, 3'($urandom), 3'b000});
         hi = {2'b00, 6'($urandom)};
         lo = {2'b00, 6'($urandom)};
         tape.push_back(hi);
         if ($urandom_range(0, 3) == 0) tape.push_back(8'hFF);
         tape.push_back(lo);
         gsum = gsum + 12'(hi) + 12'(lo);
      end
      if ($urandom_range(0, 4) == 0) begin
         tape.push_back({2'b00, 6'($urandom)});
         tape.push_back(($urandom_range(0, 1) == 1) ? 8'h80 : {2'b01, 6'($urandom)});
      end else begin
         tape.push_back({2'b00, gsum[11:6]});
         if ($urandom_range(0, 1) == 1)
            tape.push_back({2'b00, gsum[5:0]});
         else
            tape.push_back({2'b00, gsum[5:0] ^ 6'h01});
         tape.push_back(8'h80);
      end
   endtask

   initial begin
      m_addr = '0;
      #1;
      check_output("power_on_reset", {mem_addr, mem_field, mem_wdata, mem_we, busy, done, cksum_err}, '0);
      apply_reset();

      tape = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h42, 8'h00, 8'h12, 8'h34, 8'h02, 8'h08, 8'h80};
      apply_stimulus("basic");
      check_output("basic_write_const", obs_w.size() > 0 ? obs_w[0] : '0, {3'd0, 12'h080, 12'h4B4});
      check_output("basic_we_timing", obs_cyc.size() > 0 ? obs_cyc[0] : -1, strobe_cyc[9]);
      check_output("basic_err_const", cksum_err, 1'b0);

      tape = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h42, 8'h00, 8'h12, 8'h34, 8'h02, 8'h09, 8'h80};
      apply_stimulus("badsum");
      check_output("badsum_err_const", {done, cksum_err}, 2'b11);

      tape = '{8'h80, 8'h80, 8'h80, 8'h80, 8'hD0, 8'h7F, 8'h3F, 8'h01, 8'h01,
               8'h00, 8'h02, 8'h03, 8'h02, 8'h80};
      apply_stimulus("wrap");
      check_output("wrap_write0_const", obs_w.size() > 0 ? obs_w[0] : '0, {3'd2, 12'hFFF, 12'h041});
      check_output("wrap_write1_const", obs_w.size() > 1 ? obs_w[1] : '0, {3'd2, 12'h000, 12'h002});

      tape = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h42, 8'h00, 8'h12, 8'hFF, 8'h34, 8'h02, 8'h08, 8'h80};
      apply_stimulus("rubout");
      check_output("rubout_write_const", obs_w.size() > 0 ? obs_w[0] : '0, {3'd0, 12'h080, 12'h4B4});

      tape = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h42, 8'h00, 8'h12, 8'h34, 8'h05, 8'h06, 8'h02, 8'h80};
      apply_stimulus("framing");
      check_output("framing_const", {done, cksum_err, 5'(obs_w.size())}, {2'b11, 5'd1});

      for (int t = 0; t < 20; t++) begin
         gen_random_tape();
         apply_stimulus("random");
      end

      apply_reset();
      tape = '{8'h80, 8'h80, 8'h80, 8'h42, 8'h00, 8'h12, 8'h34, 8'h02, 8'h08};
      apply_stimulus("short_leader");
      check_output("short_leader_const", {busy, done, 5'(obs_w.size())}, {2'b10, 5'd0});

      apply_reset();
      arm();
      obs_w.delete();
      tape = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h42, 8'h00, 8'h12, 8'h34, 8'h05};
      foreach (tape[k]) send_byte(tape[k]);
      @(negedge clk);
      rx_data = 8'h06;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      check_output("midreset_we_before", mem_we, 1'b1);
      reset = 1'b1;
      #1;
      check_output("midreset_outputs", {mem_addr, mem_field, mem_wdata, mem_we, busy, done, cksum_err}, '0);
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      obs_w.delete();
      send_byte(8'h02);
      send_byte(8'h08);
      send_byte(8'h80);
      check_output("midreset_no_writes", obs_w.size(), 0);
      check_output("midreset_idle", {busy, done, cksum_err}, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bin_loader.md
# bin_loader

Hardware paper-tape BIN-format loader for the CPLDP-8. It consumes received bytes from the serial receiver and writes the decoded 12-bit words into external RAM at field:address, holding the CPU idle while loading. It decodes leader/trailer, origin, field-setting and data frames, and verifies the trailing checksum word. It sits between the serial receive path and the RAM bus, and is arbitrated ahead of the CPU by `busy`.

## Interface
Parameters:
- `MIN_LEADER`, default 4: number of consecutive leader bytes (0x80) required before frames are accepted.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: single-cycle pulse that arms the loader. Ignored while `busy`=1.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: single-cycle strobe qualifying `rx_data`. The source guarantees at least 2 idle cycles between strobes.
- `mem_addr` out 12: write address.
- `mem_field` out 3: write field.
- `mem_wdata` out 12: write data.
- `mem_we` out 1: single-cycle write strobe. `mem_addr`, `mem_field` and `mem_wdata` are valid in the same cycle.
- `busy` out 1: loader owns the RAM bus; CPU must be held.
- `done` out 1: tape finished; stays high until the next `start` or `reset`.
- `cksum_err` out 1: checksum mismatch or framing error; valid when `done`=1.

## Operation
- Byte classes:
  - Leader/trailer: 0x80.
  - Rubout: 0xFF, always ignored.
  - Field setting: bits[7:6]=11 and bits[2:0]=000. New field = bits[5:3].
  - Origin high: bits[7:6]=01.
  - Data high: bits[7:6]=00.
  - Low byte: must have bits[7:6]=00.
- A frame word is {hi[5:0], lo[5:0]}.
- States:
  - IDLE: on `start`, clear the leader counter, checksum and pending flag; go to LEAD. `busy`=1.
  - LEAD: count 0x80 bytes. Any other byte resets the count to 0. Once count ≥ MIN_LEADER and a non-0x80, non-rubout byte arrives, process that byte in HI.
  - HI: expect a frame high byte.
    - Origin or data high byte: latch it, go to LO.
    - Field byte: commit the pending word first, then load the field register. No checksum contribution. Stay in HI.
    - 0x80 with a word pending: trailer; go to CHECK.
    - 0x80 with no word pending: stay in HI.
  - LO: any low byte with bits[7:6]≠00 (including 0x80) is a framing error: set `cksum_err`, go to FIN. Otherwise complete the frame:
    - Commit the previous pending word (see below).
    - The new frame becomes pending with type origin or data.
    - Return to HI.
  - CHECK: compare the 12-bit running sum to the pending word. Mismatch sets `cksum_err`. Go to FIN.
  - FIN: `done`=1, `busy`=0. `start` goes to IDLE-arm (same actions as IDLE on `start`).
- Commit of a pending frame:
  - Add both of its raw 8-bit bytes, zero-extended, to the 12-bit checksum (mod 4096).
  - If origin: address register ← word.
  - If data: pulse `mem_we` with {field, address, word}, then address ← address+1. Address wraps 7777→0000 within the field and does not carry into the field.
- The final pending frame is never committed. It is the checksum.
- Field register persists across frames. It resets to 0 on `start`.

## Timing
- Reset values: `mem_addr`=0, `mem_field`=0, `mem_wdata`=0, `mem_we`=0, `busy`=0, `done`=0, `cksum_err`=0. State=IDLE.
- `mem_we` asserts in the cycle after the `rx_valid` that completes the committing frame's low byte, or after the field byte that forces a commit. It is high for exactly 1 cycle.
- `done` and `cksum_err` assert 1 cycle after the trailer `rx_valid`, or after the erroring byte.
- `busy` rises the cycle after `start` and falls together with `done` rising.
- `reset` mid-tape aborts immediately. No further writes occur.
- Rubout between the high and low byte of a frame is ignored and does not break the frame.

## Structure
- Shared package `pdp8_pkg`:
  - State enum (IDLE, LEAD, HI, LO, CHECK, FIN).
  - Constants `BIN_LEADER`=8'h80, `BIN_RUBOUT`=8'hFF.
  - Byte-class decode function.
- Single module, no sub-modules.
- Datapath registers: hi latch, pending word, pending type, address counter, field, checksum accumulator, leader counter.

## Test plan
- Basic load:
  - Stimulus: start; 4×0x80; 0x42,0x00; 0x12,0x34; 0x02,0x08; 0x80.
  - Required: one write, field 0, addr 0x080, data 0x4B4. `done`=1, `cksum_err`=0.
- Bad checksum:
  - Stimulus: same tape with checksum bytes 0x02,0x09.
  - Required: identical write, `done`=1, `cksum_err`=1.
- Field change and address wrap:
  - Stimulus: 0xD0 (field 2); origin 0x7F,0x3F; data 0x01,0x01; data 0x00,0x02; correct checksum; trailer.
  - Required: writes at (2,0xFFF)=0x041 and (2,0x000)=0x002.
- Framing error and rubout:
  - Stimulus: 0xFF inserted between a data high byte and its low byte.
    - Required: ignored, the frame completes normally.
  - Stimulus: 0x80 sent as a low byte.
    - Required: `cksum_err`=1, `done`=1, no further `mem_we`.
- Short leader and mid-tape reset:
  - Stimulus: 3×0x80 then an origin.
    - Required: bytes ignored, state stays LEAD, no `mem_we`.
  - Stimulus: `reset` asserted mid-data.
    - Required: all outputs return to reset values the same cycle.
